// File: rtl/seq_alu_pkg.sv
// Shared constants and types for the sequential ALU.
// Holds the opcode encodings, the FSM state type and the default datapath width.
// Optional feature macro: SEQ_ALU_DIV_EN adds the DIV state (divider build).
package seq_alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

`ifdef SEQ_ALU_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd3
    } state_e;
`endif

endpackage

// File: rtl/seq_alu_alu_comb.sv
// Combinational single-cycle slice: AND/OR/ADD/SUB/SLT.
// Ports: a_i, b_i operands; op_i opcode; res_c_o result; valid_c_o high when
// op_i is one of the single-cycle opcodes handled here.
module alu_comb
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] res_c_o,
    output logic             valid_c_o
);

    always_comb begin
        res_c_o   = '0;
        valid_c_o = 1'b1;
        case (op_i)
            OP_AND:  res_c_o = a_i & b_i;
            OP_OR:   res_c_o = a_i | b_i;
            OP_ADD:  res_c_o = a_i + b_i;
            OP_SUB:  res_c_o = a_i - b_i;
            OP_SLT:  res_c_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: valid_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, iterative signed multiply and
// (optionally) iterative unsigned restoring division.
// Ports: clk, rst_n (async, active-low); start/srcA/srcB/AluCon request;
// busy, done, ALUres, ALUhi, Zero, err registered results/status.
// Optional feature macro: SEQ_ALU_DIV_EN compiles in the divider and DIV state;
// without it DIVU is reported as an undefined opcode.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       AluCon,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUres,
    output logic [WIDTH-1:0] ALUhi,
    output logic             Zero,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;     // {hi, lo}: product or {remainder, quotient}
    logic [WIDTH-1:0]   opa_q, opa_d;     // multiplicand magnitude or divisor
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_valid;
    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_acc;
    logic [ACC_W-1:0]   mul_prod;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .a_i       (srcA),
        .b_i       (srcB),
        .op_i      (AluCon),
        .res_c_o   (alu_res),
        .valid_c_o (alu_valid)
    );

    // One shift-add step: conditionally add the multiplicand to the high half, shift right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_acc  = {mul_sum, acc_q[WIDTH-1:1]};
        mul_prod = neg_q ? -mul_acc : mul_acc;
    end

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_qbit;
    logic [ACC_W-1:0]   div_acc;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        div_rem_sh = acc_q[ACC_W-1:WIDTH-1];
        div_diff   = div_rem_sh - {1'b0, opa_q};
        div_qbit   = ~div_diff[WIDTH];
        div_acc    = {(div_qbit ? div_diff[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_qbit};
    end
`endif

    // Next-state and result update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        neg_d   = neg_q;
        res_d   = res_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        err_d   = err_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (alu_valid) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        res_d   = alu_res;
                        hi_d    = '0;
                        zero_d  = (alu_res == '0);
                        err_d   = 1'b0;
                    end else if (AluCon == OP_MUL) begin
                        state_d = ST_MUL;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(WIDTH);
                        opa_d   = srcA[WIDTH-1] ? -srcA : srcA;
                        acc_d   = {{WIDTH{1'b0}}, (srcB[WIDTH-1] ? -srcB : srcB)};
                        neg_d   = srcA[WIDTH-1] ^ srcB[WIDTH-1];
`ifdef SEQ_ALU_DIV_EN
                    end else if (AluCon == OP_DIVU && srcB != '0) begin
                        state_d = ST_DIV;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(WIDTH);
                        opa_d   = srcB;
                        acc_d   = {{WIDTH{1'b0}}, srcA};
                    end else if (AluCon == OP_DIVU) begin
                        // Divide by zero: no iteration, fixed result pattern.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        res_d   = '1;
                        hi_d    = srcA;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        res_d   = '0;
                        hi_d    = '0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = mul_acc;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    res_d   = mul_prod[WIDTH-1:0];
                    hi_d    = mul_prod[ACC_W-1:WIDTH];
                    zero_d  = (mul_prod[WIDTH-1:0] == '0);
                    err_d   = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            ST_DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = div_acc;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    res_d   = div_acc[WIDTH-1:0];
                    hi_d    = div_acc[ACC_W-1:WIDTH];
                    zero_d  = (div_acc[WIDTH-1:0] == '0);
                    err_d   = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ALUres = res_q;
    assign ALUhi  = hi_q;
    assign Zero   = zero_q;
    assign err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: transaction-level reference model checked
// every cycle, directed literal cases, random traffic, reset abort, WIDTH=8 case.
module tb_seq_alu;

    localparam int unsigned W = 32;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic           start  = 1'b0;
    logic [W-1:0]   srcA   = '0;
    logic [W-1:0]   srcB   = '0;
    logic [3:0]     AluCon = '0;
    logic           busy, done, Zero, err;
    logic [W-1:0]   ALUres, ALUhi;

    logic           start8 = 1'b0;
    logic [7:0]     a8 = '0, b8 = '0;
    logic [3:0]     op8 = '0;
    logic           busy8, done8, zero8, err8;
    logic [7:0]     res8, hi8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .srcA(srcA), .srcB(srcB), .AluCon(AluCon),
        .busy(busy), .done(done), .ALUres(ALUres), .ALUhi(ALUhi), .Zero(Zero), .err(err)
    );

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .srcA(a8), .srcB(b8), .AluCon(op8),
        .busy(busy8), .done(done8), .ALUres(res8), .ALUhi(hi8), .Zero(zero8), .err(err8)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endfunction

    // Reference: result, secondary result, error flag and latency of one request.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] h,
                                  output logic e, output int lat);
        longint p;
        r = '0; h = '0; e = 1'b0; lat = 1; p = 0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin
                p   = longint'($signed(a)) * longint'($signed(b));
                r   = p[31:0];
                h   = p[63:32];
                lat = W + 1;
            end
`ifdef SEQ_ALU_DIV_EN
            4'b1001: begin
                if (b == '0) begin
                    r = '1; h = a; e = 1'b1;
                end else begin
                    r = a / b; h = a % b; lat = W + 1;
                end
            end
`endif
            default: e = 1'b1;
        endcase
    endfunction

    // Timing model: acceptance when free, done due lat-1 edges after acceptance.
    int           edge_n = 0, free_at = 0, due_at = -1, m_lat = 0;
    logic [W-1:0] p_res = '0, p_hi = '0;
    logic         p_err = 1'b0;
    logic         exp_done = 1'b0, exp_busy = 1'b0, exp_zero = 1'b1, exp_err = 1'b0;
    logic [W-1:0] exp_res = '0, exp_hi = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n = 0; free_at = 0; due_at = -1;
            exp_done = 1'b0; exp_busy = 1'b0; exp_res = '0; exp_hi = '0;
            exp_zero = 1'b1; exp_err = 1'b0;
        end else begin
            if (start && edge_n >= free_at) begin
                model(AluCon, srcA, srcB, p_res, p_hi, p_err, m_lat);
                due_at  = edge_n + m_lat - 1;
                free_at = edge_n + m_lat + 1;
            end
            exp_done = (edge_n == due_at);
            if (exp_done) begin
                exp_res = p_res; exp_hi = p_hi; exp_err = p_err; exp_zero = (p_res == '0);
            end
            exp_busy = (edge_n < due_at);
            edge_n++;
        end
    end

    always @(negedge clk) begin
        chk("cyc done",   64'(done),   64'(exp_done));
        chk("cyc busy",   64'(busy),   64'(exp_busy));
        chk("cyc ALUres", 64'(ALUres), 64'(exp_res));
        chk("cyc ALUhi",  64'(ALUhi),  64'(exp_hi));
        chk("cyc Zero",   64'(Zero),   64'(exp_zero));
        chk("cyc err",    64'(err),    64'(exp_err));
    end

    task automatic run_dir(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] er, input logic [W-1:0] eh,
                           input logic ee, input int elat, input bit poke);
        int n;
        int nbusy;
        @(negedge clk);
        start = 1'b1; AluCon = op; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0;
        n = 1; nbusy = 0;
        while (!done && n < 200) begin
            if (busy) nbusy++;
            if (poke && n == 5) begin
                start = 1'b1; AluCon = 4'b0010; srcA = 32'd1; srcB = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({nm, " latency"}, 64'(n), 64'(elat));
        chk({nm, " busy cycles"}, 64'(nbusy), 64'(elat - 1));
        chk({nm, " ALUres"}, 64'(ALUres), 64'(er));
        chk({nm, " ALUhi"}, 64'(ALUhi), 64'(eh));
        chk({nm, " err"}, 64'(err), 64'(ee));
        chk({nm, " Zero"}, 64'(Zero), 64'(er == '0));
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] mr, mh;
        logic         me;
        int           ml;
        int           n;

        // Pin the reference model to hand-computed values.
        model(4'b0010, 32'd14, 32'hFFFF_FFE8, mr, mh, me, ml);
        chk("model add", {mh, mr}, 64'h0000_0000_FFFF_FFF6);
        chk("model add lat", 64'(ml), 64'd1);
        model(4'b1000, 32'hFFFF_FFF9, 32'd6, mr, mh, me, ml);
        chk("model mul", {mh, mr}, 64'hFFFF_FFFF_FFFF_FFD6);
        chk("model mul lat", 64'(ml), 64'd33);
        model(4'b0111, 32'hFFFF_FFFF, 32'd1, mr, mh, me, ml);
        chk("model slt", 64'(mr), 64'd1);

        repeat (3) @(negedge clk);
        chk("reset ALUres", 64'(ALUres), 64'd0);
        chk("reset Zero", 64'(Zero), 64'd1);
        chk("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        run_dir("add",     4'b0010, 32'd14, 32'hFFFF_FFE8, 32'hFFFF_FFF6, 32'd0, 1'b0, 1, 1'b0);
        run_dir("sub",     4'b0110, 32'h55, 32'h55, 32'd0, 32'd0, 1'b0, 1, 1'b0);
        run_dir("slt",     4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1, 1'b0);
        run_dir("and",     4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'd0, 1'b0, 1, 1'b0);
        run_dir("or",      4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 32'd0, 1'b0, 1, 1'b0);
        run_dir("mul",     4'b1000, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
        run_dir("mul min", 4'b1000, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h4000_0000, 1'b0, 33, 1'b0);
`ifdef SEQ_ALU_DIV_EN
        run_dir("divu",    4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0);
        run_dir("divu0",   4'b1001, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1, 1, 1'b0);
`else
        run_dir("divu",    4'b1001, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        run_dir("divu0",   4'b1001, 32'd100, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1'b0);
`endif
        run_dir("undef",   4'b0011, 32'd5, 32'd6, 32'd0, 32'd0, 1'b1, 1, 1'b0);

        // Abort a multiply with reset, then start an ADD on the first edge after release.
        @(negedge clk);
        start = 1'b1; AluCon = 4'b1000; srcA = 32'hFFFF_FFF9; srcB = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst ALUres", 64'(ALUres), 64'd0);
        chk("rst ALUhi", 64'(ALUhi), 64'd0);
        chk("rst Zero", 64'(Zero), 64'd1);
        chk("rst err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; AluCon = 4'b0010; srcA = 32'd3; srcB = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("post-rst add done", 64'(done), 64'd1);
        chk("post-rst add res", 64'(ALUres), 64'd7);

        // Random traffic, including requests while busy and back-to-back starts.
        repeat (4000) begin
            @(negedge clk);
            start = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0:       AluCon = 4'b0000;
                1:       AluCon = 4'b0001;
                2:       AluCon = 4'b0010;
                3:       AluCon = 4'b0110;
                4:       AluCon = 4'b0111;
                5:       AluCon = 4'b1000;
                6, 7:    AluCon = 4'b1001;
                default: AluCon = 4'($urandom);
            endcase
            srcA = rnd_operand();
            srcB = rnd_operand();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Narrow instance: -128 * -128.
        @(negedge clk);
        start8 = 1'b1; op8 = 4'b1000; a8 = 8'h80; b8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w8 mul latency", 64'(n), 64'd9);
        chk("w8 mul ALUhi", 64'(hi8), 64'h40);
        chk("w8 mul ALUres", 64'(res8), 64'h00);
        chk("w8 mul err", 64'(err8), 64'd0);
        chk("w8 mul Zero", 64'(zero8), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; legal range 8..64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle request strobe; sampled only in IDLE.
REQ-005 srcA  input  WIDTH  operand A; captured when start is accepted.
REQ-006 srcB  input  WIDTH  operand B; captured when start is accepted.
REQ-007 AluCon  input  4  opcode; captured when start is accepted.
REQ-008 busy  output  1  high from the cycle after acceptance until done.
REQ-009 done  output  1  one-cycle pulse; results are valid in this cycle.
REQ-010 ALUres  output  WIDTH  primary result (low product, quotient, logic/arith result).
REQ-011 ALUhi  output  WIDTH  secondary result (high product, remainder); 0 for single-cycle ops.
REQ-012 Zero  output  1  high when ALUres == 0; updated together with ALUres.
REQ-013 err  output  1  high with done for divide-by-zero or a disabled/undefined opcode.

Function
REQ-014 Opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, result 1/0); 1000 MUL (signed); 1001 DIVU (unsigned); all others undefined.
REQ-015 FSM states: IDLE, MUL, DIV, DONE; reset state is IDLE.
REQ-016 IDLE with start=1: single-cycle opcodes go to DONE, MUL goes to MUL, DIVU goes to DIV.
REQ-017 Single-cycle ops: results are registered on acceptance; done is asserted in the next cycle (latency 1).
REQ-018 MUL: shift-add on operand magnitudes, one bit per cycle for WIDTH cycles, then the 2*WIDTH result is negated if the operand signs differ; done at cycle WIDTH+1 after acceptance.
REQ-019 DIVU: restoring division, one bit per cycle for WIDTH cycles; done at cycle WIDTH+1; ALUres=quotient, ALUhi=remainder.
REQ-020 DIVU with srcB=0: no iteration; ALUres=all ones, ALUhi=srcA, err=1; done at latency 1.
REQ-021 Undefined opcode: ALUres=0, ALUhi=0, err=1; done at latency 1.
REQ-022 ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
REQ-023 start while busy=1 or in DONE is ignored, with no queueing.
REQ-024 DONE returns to IDLE after one cycle; a start in that IDLE cycle is accepted, giving back-to-back throughput.
REQ-025 ALUres, ALUhi, Zero and err hold their values after done until the next done.
REQ-026 The iteration counter is ceil(log2(WIDTH+1)) bits wide, counts down from WIDTH, and exits the iteration state at 0.

Reset
REQ-027 rst_n low forces state=IDLE, busy=0, done=0, ALUres=0, ALUhi=0, Zero=1, err=0, and counter=0.
REQ-028 Reset during MUL/DIV aborts the operation; no done is produced for it.
REQ-029 The first start is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro SEQ_ALU_DIV_EN defined: the divider datapath and DIV state are compiled in, and REQ-019/020 apply.
REQ-031 Macro SEQ_ALU_DIV_EN undefined: no divider logic or DIV state; DIVU behaves as an undefined opcode (REQ-021).

Structure
REQ-032 Package seq_alu_pkg holds the opcode constants, the FSM state typedef and the default WIDTH constant.
REQ-033 Sub-module alu_comb is the combinational AND/OR/ADD/SUB/SLT slice, parametrised by WIDTH and instantiated once.

Verification
REQ-034 WIDTH=32, ADD, srcA=14, srcB=-24 -> done at 1 cycle, ALUres=0xFFFFFFF6, Zero=0, err=0.
REQ-035 SUB, srcA=srcB=0x55 -> ALUres=0, Zero=1; SLT with srcA=-1, srcB=1 -> ALUres=1.
REQ-036 MUL, srcA=-7, srcB=6 -> done at exactly 33 cycles, ALUhi:ALUres=-42 (ALUhi=0xFFFFFFFF, ALUres=0xFFFFFFD6), busy high for 32 cycles; a start pulse mid-operation is ignored.
REQ-037 DIVU, srcA=100, srcB=7 -> done at 33 cycles, ALUres=14, ALUhi=2; srcB=0 -> 1 cycle, ALUres=0xFFFFFFFF, ALUhi=100, err=1 (without SEQ_ALU_DIV_EN: ALUres=0, err=1).
REQ-038 rst_n pulsed low 10 cycles into a MUL -> no done, outputs at reset values, and an ADD 3+4 started in the first cycle after reset returns 7.
REQ-039 WIDTH=8, MUL 0x80*0x80 (-128*-128) -> done at 9 cycles, ALUhi=0x40, ALUres=0x00.
